// File: rtl/axis_hdr_pkg.sv
// Shared types and constants for the Ethernet L2 header tagger.
//   state_e    : tagger control FSM states
//   eth_hdr_t  : tuser layout {flags, etype, src_mac, dst_mac}, 128 bits
//   FLAG_*     : bit positions inside eth_hdr_t.flags
//   count_bytes: number of set byte enables in a 16-byte header window
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  typedef struct packed {
    logic [15:0] flags;
    logic [15:0] etype;
    logic [47:0] src_mac;
    logic [47:0] dst_mac;
  } eth_hdr_t;

  localparam int          FLAG_RUNT     = 0;
  localparam int          FLAG_VLAN     = 1;
  localparam int          FLAG_BCAST    = 2;
  localparam int          FLAG_MCAST    = 3;
  localparam logic [15:0] ETYPE_VLAN    = 16'h8100;
  localparam int          MIN_HDR_BYTES = 14;

  function automatic int count_bytes(input logic [15:0] bv);
    return $countones(bv);
  endfunction

endpackage

// File: rtl/eth_hdr_decode.sv
// Combinational Ethernet L2 header decoder.
//   i_beat0/i_keep0 : first beat of the packet and its byte enables
//   i_beat1/i_keep1 : second beat and its byte enables
//   i_beat1_vld     : second beat belongs to the packet (beat0 was not tlast)
//   o_hdr           : decoded {flags, etype, src_mac, dst_mac}
// Bytes that are not enabled decode as zero, so a runt header yields zeroed
// fields for the bytes it never carried.
module eth_hdr_decode
  import axis_hdr_pkg::*;
(
  input  logic [63:0] i_beat0,
  input  logic [7:0]  i_keep0,
  input  logic [63:0] i_beat1,
  input  logic [7:0]  i_keep1,
  input  logic        i_beat1_vld,
  output eth_hdr_t    o_hdr
);

  logic [15:0]      w_bv;
  logic [15:0][7:0] w_byte;
  logic             w_bcast;
  eth_hdr_t         w_hdr;

  assign w_bv = {(i_beat1_vld ? i_keep1 : 8'h00), i_keep0};

  for (genvar g = 0; g < 8; g++) begin : g_byte
    assign w_byte[g]     = w_bv[g]     ? i_beat0[8*g +: 8] : 8'h00;
    assign w_byte[g + 8] = w_bv[g + 8] ? i_beat1[8*g +: 8] : 8'h00;
  end

  always_comb begin
    w_hdr         = '0;
    w_hdr.dst_mac = {w_byte[0], w_byte[1], w_byte[2], w_byte[3], w_byte[4], w_byte[5]};
    w_hdr.src_mac = {w_byte[6], w_byte[7], w_byte[8], w_byte[9], w_byte[10], w_byte[11]};
    w_hdr.etype   = {w_byte[12], w_byte[13]};
    w_bcast       = (w_hdr.dst_mac == 48'hFFFF_FFFF_FFFF);
    w_hdr.flags[FLAG_RUNT]  = (count_bytes(w_bv) < MIN_HDR_BYTES);
    w_hdr.flags[FLAG_VLAN]  = (w_hdr.etype == ETYPE_VLAN);
    w_hdr.flags[FLAG_BCAST] = w_bcast;
    // Broadcast is reported only as bcast; mcast marks group addresses other
    // than all-ones so downstream stages see exactly one address class.
    w_hdr.flags[FLAG_MCAST] = w_byte[0][0] & ~w_bcast;
  end

  assign o_hdr = w_hdr;

endmodule

// File: rtl/axis_eth_hdr_tagger.sv
// AXI-Stream Ethernet L2 header tagger. Passes packets through unmodified and
// attaches the decoded header plus classification flags on m_axis_tuser,
// constant for every beat of the packet. One beat is buffered (H) so the
// header, which spans beats 0-1, is known before the first beat leaves (O).
// Ports:
//   aclk, areset                  : clock, synchronous active-high reset
//   s_axis_t{data,keep,valid,last}: ingress stream, s_axis_tready combinational
//   m_axis_t{data,keep,valid,last,user}: egress stream, all registered
//   m_axis_tready                 : egress ready
// Optional (`AXIS_HDR_STATS_EN): stat_pkt_cnt (32b), stat_runt_cnt (16b)
// counting egress tlast handshakes, all / runt only, wrapping.
module axis_eth_hdr_tagger
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 128
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  input  logic                    m_axis_tready
`ifdef AXIS_HDR_STATS_EN
  ,
  output logic [31:0]             stat_pkt_cnt,
  output logic [15:0]             stat_runt_cnt
`endif
);

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("axis_eth_hdr_tagger: DATA_WIDTH must be 64");
  end
  if (USER_WIDTH != 128) begin : g_bad_user_width
    $error("axis_eth_hdr_tagger: USER_WIDTH must be 128");
  end

  state_e                  r_state;
  state_e                  w_next_state;
  logic                    w_adv;
  logic                    w_s_ready;
  logic                    w_s_fire;
  logic                    w_o_load;
  logic                    w_o_user_dec;
  logic                    w_hdr_we;

  logic [DATA_WIDTH-1:0]   r_h_data;
  logic [DATA_WIDTH/8-1:0] r_h_keep;
  logic                    r_h_last;
  eth_hdr_t                r_hdr;

  logic [DATA_WIDTH-1:0]   r_o_data;
  logic [DATA_WIDTH/8-1:0] r_o_keep;
  logic                    r_o_last;
  logic                    r_o_valid;
  eth_hdr_t                r_o_user;

  logic [63:0]             w_dec_beat0;
  logic [7:0]              w_dec_keep0;
  eth_hdr_t                w_dec_hdr;

  // O may take a new beat when it is empty or its current beat leaves now.
  assign w_adv    = !r_o_valid || m_axis_tready;
  assign w_s_fire = s_axis_tvalid && w_s_ready;

  // In IDLE only a 1-beat packet needs decoding, straight from the ingress
  // beat; in HDR beat0 sits in H and beat1 is on the ingress port.
  assign w_dec_beat0 = (r_state == IDLE) ? s_axis_tdata : r_h_data;
  assign w_dec_keep0 = (r_state == IDLE) ? s_axis_tkeep : r_h_keep;

  eth_hdr_decode u_dec (
    .i_beat0     (w_dec_beat0),
    .i_keep0     (w_dec_keep0),
    .i_beat1     (s_axis_tdata),
    .i_keep1     (s_axis_tkeep),
    .i_beat1_vld (r_state == HDR),
    .o_hdr       (w_dec_hdr)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_s_ready    = 1'b0;
    w_o_load     = 1'b0;
    w_o_user_dec = 1'b0;
    w_hdr_we     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_s_ready = 1'b1;
        if (s_axis_tvalid) begin
          w_hdr_we     = s_axis_tlast;
          w_next_state = s_axis_tlast ? FLUSH : HDR;
        end
      end
      HDR: begin
        w_s_ready = w_adv;
        if (s_axis_tvalid && w_adv) begin
          w_o_load     = 1'b1;
          w_o_user_dec = 1'b1;
          w_hdr_we     = 1'b1;
          w_next_state = s_axis_tlast ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        w_s_ready = w_adv;
        if (s_axis_tvalid && w_adv) begin
          w_o_load     = 1'b1;
          w_next_state = s_axis_tlast ? FLUSH : STREAM;
        end
      end
      FLUSH: begin
        if (w_adv) begin
          w_o_load     = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // H: one-beat holding register; O: egress register driving m_axis_*.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_h_data  <= '0;
      r_h_keep  <= '0;
      r_h_last  <= 1'b0;
      r_hdr     <= '0;
      r_o_data  <= '0;
      r_o_keep  <= '0;
      r_o_last  <= 1'b0;
      r_o_user  <= '0;
      r_o_valid <= 1'b0;
    end else begin
      if (w_s_fire) begin
        r_h_data <= s_axis_tdata;
        r_h_keep <= s_axis_tkeep;
        r_h_last <= s_axis_tlast;
      end
      if (w_hdr_we) begin
        r_hdr <= w_dec_hdr;
      end
      if (w_o_load) begin
        r_o_data  <= r_h_data;
        r_o_keep  <= r_h_keep;
        r_o_last  <= r_h_last;
        r_o_user  <= w_o_user_dec ? w_dec_hdr : r_hdr;
        r_o_valid <= 1'b1;
      end else if (m_axis_tready) begin
        r_o_valid <= 1'b0;
      end
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_o_data;
  assign m_axis_tkeep  = r_o_keep;
  assign m_axis_tlast  = r_o_last;
  assign m_axis_tvalid = r_o_valid;
  assign m_axis_tuser  = r_o_user;

`ifdef AXIS_HDR_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [15:0] r_runt_cnt;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pkt_cnt  <= '0;
      r_runt_cnt <= '0;
    end else if (r_o_valid && m_axis_tready && r_o_last) begin
      r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (r_o_user.flags[FLAG_RUNT]) begin
        r_runt_cnt <= r_runt_cnt + 16'd1;
      end
    end
  end

  assign stat_pkt_cnt  = r_pkt_cnt;
  assign stat_runt_cnt = r_runt_cnt;
`endif

endmodule

// File: tb/tb_axis_eth_hdr_tagger.sv
// Self-checking bench for axis_eth_hdr_tagger. Directed packets with
// hand-computed tuser values; egress beats are collected by a monitor and
// compared beat-by-beat against the expected queue.
// Define AXIS_HDR_STATS_EN to also exercise the statistics counters.
module tb_axis_eth_hdr_tagger;

  typedef struct packed {
    logic [63:0]  d;
    logic [7:0]   k;
    logic         l;
    logic [127:0] u;
  } beat_t;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [63:0]  s_axis_tdata = '0;
  logic [7:0]   s_axis_tkeep = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tready;
`ifdef AXIS_HDR_STATS_EN
  logic [31:0]  stat_pkt_cnt;
  logic [15:0]  stat_runt_cnt;
`endif

  int    n_checks = 0;
  int    n_fail = 0;
  beat_t tx_q[$];
  beat_t exp_q[$];
  beat_t mon_q[$];
  bit    rnd_en = 1'b0;
  int    stall_err = 0;
  int    in_stall = 0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t mon_cur;

  axis_eth_hdr_tagger #(.DATA_WIDTH(64), .USER_WIDTH(128)) u_dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready)
`ifdef AXIS_HDR_STATS_EN
    ,
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_runt_cnt (stat_runt_cnt)
`endif
  );

  initial begin
    forever #5 aclk = ~aclk;
  end

  // Egress ready: held high, or a random 50% pattern when rnd_en is set.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples mid-cycle, records handshakes, stall stability and
  // ingress stall cycles.
  always @(negedge aclk) begin
    mon_cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_axis_tvalid || mon_cur !== prev_beat)) stall_err++;
      if (m_axis_tvalid && m_axis_tready) mon_q.push_back(mon_cur);
      if (s_axis_tvalid && !s_axis_tready) in_stall++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = mon_cur;
    end
  end

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    tx_q.delete();
    exp_q.delete();
    mon_q.delete();
  endtask

  task automatic build_pkt(input logic [47:0] dst, input logic [47:0] src,
                           input logic [15:0] et, input int len, input int seed,
                           input logic [127:0] user);
    logic [7:0] b [0:127];
    beat_t      bt;
    for (int i = 0; i < 6; i++) begin
      b[i]     = dst[8*(5-i) +: 8];
      b[6 + i] = src[8*(5-i) +: 8];
    end
    b[12] = et[15:8];
    b[13] = et[7:0];
    for (int i = 14; i < 128; i++) b[i] = 8'(seed * 17 + i);
    for (int bi = 0; bi * 8 < len; bi++) begin
      bt.d = '0;
      bt.k = '0;
      for (int j = 0; j < 8; j++) begin
        bt.d[8*j +: 8] = b[bi*8 + j];
        if (bi * 8 + j < len) bt.k[j] = 1'b1;
      end
      bt.l = ((bi + 1) * 8 >= len);
      bt.u = user;
      tx_q.push_back(bt);
      exp_q.push_back(bt);
    end
  endtask

  task automatic send_beat(input beat_t b);
    int cyc;
    cyc = 0;
    s_axis_tdata  = b.d;
    s_axis_tkeep  = b.k;
    s_axis_tlast  = b.l;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && cyc < 1000) begin
      @(negedge aclk);
      cyc++;
    end
    if (!s_axis_tready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_beat timeout: s_axis_tready=%0b, required 1", s_axis_tready);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_all();
    beat_t b;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      send_beat(b);
    end
  endtask

  task automatic wait_beats(input int n);
    int cyc;
    cyc = 0;
    while (mon_q.size() < n && cyc < 3000) begin
      @(posedge aclk);
      cyc++;
    end
    repeat (4) @(posedge aclk);
    #1;
  endtask

  function automatic logic [127:0] mk_user(input logic [47:0] dst, input logic [47:0] src,
                                           input logic [15:0] et);
    logic bc, mc, vl;
    bc = (dst == 48'hFFFF_FFFF_FFFF);
    mc = dst[40] && !bc;
    vl = (et == 16'h8100);
    return {12'h000, mc, bc, vl, 1'b0, et, src, dst};
  endfunction

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tvalid: got %0b, expected 0", m_axis_tvalid);
    end
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready: got %0b, expected 1", s_axis_tready);
    end
    n_checks++;
    if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h keep=%h last=%0b user=%h, expected all 0",
               m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
    end
  endtask

  task automatic test_bcast();
    do_reset();
    build_pkt(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 64, 1,
              {16'h0004, 16'h0800, 48'h0011_2233_4455, 48'hFFFF_FFFF_FFFF});
    send_all();
    wait_beats(8);
    n_checks++;
    if (mon_q.size() !== 8) begin
      n_fail++;
      $display("FAIL bcast_count: got %0d beats, expected 8", mon_q.size());
    end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bcast_beat%0d: got %h, expected %h", i, mon_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (mon_q.size() == 0 || mon_q[0].u[127:112] !== 16'h0004) begin
      n_fail++;
      $display("FAIL bcast_flags: got %h, expected 0004",
               (mon_q.size() > 0) ? mon_q[0].u[127:112] : 16'hxxxx);
    end
  endtask

  task automatic test_vlan();
    do_reset();
    build_pkt(48'h0100_5E00_0001, 48'h0011_2233_4456, 16'h8100, 24, 2,
              {16'h000A, 16'h8100, 48'h0011_2233_4456, 48'h0100_5E00_0001});
    send_all();
    wait_beats(3);
    n_checks++;
    if (mon_q.size() !== 3) begin
      n_fail++;
      $display("FAIL vlan_count: got %0d beats, expected 3", mon_q.size());
    end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL vlan_beat%0d: got %h, expected %h", i, mon_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (mon_q.size() == 0 || mon_q[0].u[111:96] !== 16'h8100) begin
      n_fail++;
      $display("FAIL vlan_etype: got %h, expected 8100",
               (mon_q.size() > 0) ? mon_q[0].u[111:96] : 16'hxxxx);
    end
  endtask

  task automatic test_runt();
    do_reset();
    // 10-byte runt: src_mac low bytes and etype never arrive.
    build_pkt(48'h0200_0000_0001, 48'hAABB_CCDD_EEFF, 16'h0800, 10, 3,
              {16'h0001, 16'h0000, 48'hAABB_CCDD_0000, 48'h0200_0000_0001});
    // 6-byte single-beat runt with a broadcast destination.
    build_pkt(48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 16'h0800, 6, 4,
              {16'h0005, 16'h0000, 48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF});
    send_all();
    wait_beats(3);
    n_checks++;
    if (mon_q.size() !== 3) begin
      n_fail++;
      $display("FAIL runt_count: got %0d beats, expected 3", mon_q.size());
    end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL runt_beat%0d: got %h, expected %h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      dst = {8'h00, 32'h0, 8'(p + 16)};
      src = {16'h5555, 32'(p)};
      et  = 16'h0800;
      build_pkt(dst, src, et, 24, 10 + p, {16'h0000, et, src, dst});
    end
    in_stall = 0;
    send_all();
    wait_beats(9);
    n_checks++;
    if (in_stall !== 2) begin
      n_fail++;
      $display("FAIL b2b_bubbles: got %0d ingress stall cycles, expected 2", in_stall);
    end
    n_checks++;
    if (mon_q !== exp_q) begin
      n_fail++;
      $display("FAIL b2b_data: got %0d beats, expected %0d matching beats", mon_q.size(), exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
    int          bad;
    do_reset();
    for (int p = 0; p < 20; p++) begin
      dst = (p == 7) ? 48'hFFFF_FFFF_FFFF : {8'(p % 2), 32'h0, 8'(p)};
      src = {16'hABCD, 32'(p)};
      et  = (p % 4 == 1) ? 16'h8100 : 16'h0800;
      build_pkt(dst, src, et, 24, 20 + p, mk_user(dst, src, et));
    end
    stall_err = 0;
    rnd_en = 1'b1;
    send_all();
    wait_beats(60);
    rnd_en = 1'b0;
    n_checks++;
    if (mon_q.size() !== 60) begin
      n_fail++;
      $display("FAIL bp_count: got %0d beats, expected 60", mon_q.size());
    end
    bad = 0;
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      if (mon_q[i] !== exp_q[i]) begin
        bad++;
        if (bad <= 4) $display("FAIL bp_beat%0d: got %h, expected %h", i, mon_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_scoreboard: got %0d wrong beats, expected 0", bad);
    end
    n_checks++;
    if (stall_err !== 0) begin
      n_fail++;
      $display("FAIL bp_stall_stable: got %0d unstable stalled cycles, expected 0", stall_err);
    end
  endtask

  task automatic test_reset_midpkt();
    beat_t b;
    do_reset();
    build_pkt(48'h0200_0000_0099, 48'h0102_0304_0506, 16'h0800, 64, 30,
              {16'h0000, 16'h0800, 48'h0102_0304_0506, 48'h0200_0000_0099});
    for (int i = 0; i < 3; i++) begin
      b = tx_q.pop_front();
      send_beat(b);
    end
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_tvalid: got %0b, expected 0", m_axis_tvalid);
    end
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_tready: got %0b, expected 1", s_axis_tready);
    end
    tx_q.delete();
    exp_q.delete();
    mon_q.delete();
    build_pkt(48'h00AA_00BB_00CC, 48'h1122_3344_5566, 16'h86DD, 16, 31,
              {16'h0000, 16'h86DD, 48'h1122_3344_5566, 48'h00AA_00BB_00CC});
    send_all();
    wait_beats(2);
    n_checks++;
    if (mon_q !== exp_q) begin
      n_fail++;
      $display("FAIL midrst_next_pkt: got %0d beats (first %h), expected %0d (first %h)",
               mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : '0, exp_q.size(), exp_q[0]);
    end
  endtask

`ifdef AXIS_HDR_STATS_EN
  task automatic test_stats();
    do_reset();
    build_pkt(48'h0200_0000_0001, 48'h1, 16'h0800, 24, 40, '0);
    build_pkt(48'h0200_0000_0002, 48'h2, 16'h0800, 10, 41, '0);
    build_pkt(48'h0200_0000_0003, 48'h3, 16'h0800, 24, 42, '0);
    build_pkt(48'h0200_0000_0004, 48'h4, 16'h0800, 6,  43, '0);
    build_pkt(48'h0200_0000_0005, 48'h5, 16'h0800, 16, 44, '0);
    send_all();
    wait_beats(11);
    n_checks++;
    if (stat_pkt_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL stat_pkt_cnt: got %0d, expected 5", stat_pkt_cnt);
    end
    n_checks++;
    if (stat_runt_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL stat_runt_cnt: got %0d, expected 2", stat_runt_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bcast();
    test_vlan();
    test_runt();
    test_back_to_back();
    test_backpressure();
    test_reset_midpkt();
`ifdef AXIS_HDR_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
